fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter instWidth, default 32, meaning instruction width in bits.
REQ-002 The module SHALL have parameter lsAddrWidth, default 15, meaning local-store byte-address width (32 KB).
REQ-003 The module SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 The module SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The module SHALL have port stallIn  input  1  decoder busy; when high, the presented pair is not consumed.
REQ-006 The module SHALL have port branchTaken  input  1  one-cycle redirect request.
REQ-007 The module SHALL have port branchTarget  input  lsAddrWidth  redirect byte address, word aligned.
REQ-008 The module SHALL have port lsReadEn  output  1  local-store read strobe.
REQ-009 The module SHALL have port lsAddr  output  lsAddrWidth  read address, 8-byte aligned.
REQ-010 The module SHALL have port lsData  input  2*instWidth  read data, valid exactly one cycle after lsReadEn.
REQ-011 The module SHALL have port instOut  output  2*instWidth  instruction pair to decoder; [31:0] is the older instruction, [63:32] the younger.
REQ-012 The module SHALL have port pcOut  output  lsAddrWidth  byte address of instOut[31:0].

Function
REQ-013 The module SHALL use 32'hFFFFFFFF in either half of instOut as the empty-slot marker; 64'hFFFFFFFFFFFFFFFF is a bubble.
REQ-014 The module SHALL run FSM states IDLE, RUN, FLUSH: reset->IDLE; IDLE->RUN next cycle; RUN->FLUSH on branchTaken; FLUSH->RUN next cycle.
REQ-015 The module SHALL hold a 2-entry pair FIFO (data plus PC) and an inFlight flag for the outstanding read.
REQ-016 In RUN, the module SHALL assert lsReadEn when FIFO count plus inFlight is less than 2, with lsAddr equal to fetchPC, then advance fetchPC by 8.
REQ-017 fetchPC SHALL wrap modulo 2^lsAddrWidth; an address of 0x7FF8 is followed by 0x0000.
REQ-018 The module SHALL write lsData into the FIFO in the cycle after a read whose inFlight flag was not cancelled.
REQ-019 When stallIn is low and the FIFO is non-empty, the module SHALL pop the head into instOut/pcOut on the next edge; when stallIn is low and the FIFO is empty, instOut SHALL become a bubble.
REQ-020 When stallIn is high, instOut and pcOut SHALL hold, with no pop; fetch continues until the FIFO is full, and no pair is ever dropped or duplicated.
REQ-021 When the FIFO is full and a read is returning in the same cycle, the module SHALL pop before push (stallIn low) or stall issue one cycle earlier so that overflow never occurs.
REQ-022 On branchTaken, the module SHALL clear the FIFO, cancel inFlight data, drive a bubble on instOut for one cycle regardless of stallIn, and set fetchPC to branchTarget with bits [2:0] cleared.
REQ-023 If branchTarget[2] is 1, the first pair after redirect SHALL have instOut[31:0] replaced by the empty marker and pcOut = branchTarget - 4.
REQ-024 A branchTaken during FLUSH SHALL restart FLUSH with the newest target, which wins.
REQ-025 Latency from redirect to the first valid pair on instOut SHALL be 3 cycles with stallIn low.

Reset
REQ-026 Reset SHALL set the state to IDLE, fetchPC to 0, FIFO to empty, inFlight to 0, lsReadEn to 0, lsAddr to 0, instOut to all ones, and pcOut to 0.
REQ-027 Reset asserted mid-operation SHALL discard any returning lsData.

Structure
REQ-028 The FSM state enum, the empty-marker constant and the instruction-width constants SHALL live in the shared package spu_pkg.
REQ-029 The FIFO SHALL be the sub-module fetch_fifo (2-deep, push/pop/count).

Verification
REQ-030 The bench SHALL cover: reset released, stallIn=0, memory word n = n -> lsAddr 0,8,16..., instOut {1,0},{3,2}... from cycle 3.
REQ-031 The bench SHALL cover: stallIn held high 5 cycles mid-stream -> instOut constant, lsReadEn stops after the FIFO reaches 2, and the pairs resume in order with no gaps.
REQ-032 The bench SHALL cover: branchTaken with target 0x0104 -> one bubble, then instOut[31:0]=FFFFFFFF, [63:32]=word at 0x0104, pcOut=0x0100.
REQ-033 The bench SHALL cover: fetchPC at 0x7FF8 -> next lsAddr 0x0000.
REQ-034 The bench SHALL cover: branchTaken in two consecutive cycles (0x40, then 0x80) -> the first fetched pair comes from 0x80.
REQ-035 The bench SHALL cover: reset asserted while a read is in flight -> instOut all ones and no stale pair appears after release.

Source files
------------

// File: rtl/spu_pkg.sv
// Shared SPU front-end types and constants.
// Holds the fetch FSM states, instruction widths and the empty-slot marker.
package spu_pkg;

  localparam int INST_W     = 32;
  localparam int PAIR_W     = 2 * INST_W;
  localparam int LS_AW      = 15;
  localparam int PAIR_BYTES = 8;

  localparam logic [INST_W-1:0] EMPTY_SLOT = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction-pair FIFO carrying fetched data and its byte PC.
// Ports: clk_i, rst_i (sync), clr_i, push_i/data_i/pc_i, pop_i, data_o/pc_o (head), count_o.
module fetch_fifo
  import spu_pkg::*;
#(
  parameter int DW = PAIR_W,
  parameter int AW = LS_AW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic [AW-1:0] pc_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic [AW-1:0] pc_o,
  output logic [1:0]    count_o
);

  logic [DW-1:0] data_q [2];
  logic [AW-1:0] pc_q   [2];
  logic          rd_q, wr_q;
  logic [1:0]    cnt_q;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (do_push) wr_q <= ~wr_q;
      if (do_pop)  rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i && !clr_i) begin
      data_q[wr_q] <= data_i;
      pc_q[wr_q]   <= pc_i;
    end
  end

  assign data_o  = data_q[rd_q];
  assign pc_o    = pc_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// SPU instruction fetch: reads 8-byte pairs from local store and feeds the decoder.
// Ports: clk, reset (sync), stallIn, branchTaken/branchTarget, lsReadEn/lsAddr/lsData, instOut/pcOut.
module fetch_unit
  import spu_pkg::*;
#(
  parameter int instWidth   = INST_W,
  parameter int lsAddrWidth = LS_AW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stallIn,
  input  logic                   branchTaken,
  input  logic [lsAddrWidth-1:0] branchTarget,
  output logic                   lsReadEn,
  output logic [lsAddrWidth-1:0] lsAddr,
  input  logic [2*instWidth-1:0] lsData,
  output logic [2*instWidth-1:0] instOut,
  output logic [lsAddrWidth-1:0] pcOut
);

  localparam int PW = 2 * instWidth;
  localparam logic [instWidth-1:0]   EMPTY  = instWidth'(EMPTY_SLOT);
  localparam logic [PW-1:0]          BUBBLE = {EMPTY, EMPTY};
  localparam logic [lsAddrWidth-1:0] STEP   = lsAddrWidth'(PAIR_BYTES);

  fetch_state_e state_q, state_d;

  logic [lsAddrWidth-1:0] fetchPc_q, fetchPc_d;
  logic [lsAddrWidth-1:0] flightPc_q, flightPc_d;
  logic [lsAddrWidth-1:0] pc_q, pc_d;
  logic [PW-1:0]          inst_q, inst_d;
  logic                   inFlight_q, inFlight_d;
  logic                   maskLow_q, maskLow_d;

  logic                   active, redirect;
  logic                   issue, push, pop;
  logic [1:0]             count, occ;
  logic [PW-1:0]          headData, pushData;
  logic [lsAddrWidth-1:0] headPc, tgtAligned;
  logic                   unused_tgt;

  assign unused_tgt = ^branchTarget[1:0];

  assign active     = !reset && (state_q != IDLE);
  assign redirect   = active && branchTaken;
  assign tgtAligned = {branchTarget[lsAddrWidth-1:3], 3'b000};

  assign pop = active && !redirect && !stallIn && (count != 2'd0);
  assign occ = count + {1'b0, inFlight_q};
  // Counting the same-cycle pop keeps the stream gap-free without overflow.
  // A redirect always issues at the new target in its own cycle.
  assign issue = active && (redirect || (occ < 2'd2) || pop);

  // Data landing in a redirect cycle belongs to the old stream: dropped.
  assign push     = active && inFlight_q && !redirect;
  assign pushData = maskLow_q ? {lsData[PW-1:instWidth], EMPTY} : lsData;

  assign lsReadEn = issue;
  assign lsAddr   = reset    ? '0 :
                    redirect ? tgtAligned : fetchPc_q;

  fetch_fifo #(
    .DW(PW),
    .AW(lsAddrWidth)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (reset),
    .clr_i  (redirect),
    .push_i (push),
    .data_i (pushData),
    .pc_i   (flightPc_q),
    .pop_i  (pop),
    .data_o (headData),
    .pc_o   (headPc),
    .count_o(count)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (branchTaken) state_d = FLUSH;
      FLUSH:   if (!branchTaken) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fetchPc_d  = fetchPc_q;
    flightPc_d = flightPc_q;
    maskLow_d  = maskLow_q;
    inst_d     = inst_q;
    pc_d       = pc_q;
    inFlight_d = issue;
    if (redirect) begin
      fetchPc_d = tgtAligned + STEP;
      maskLow_d = branchTarget[2];
      inst_d    = BUBBLE;
    end else begin
      if (issue) fetchPc_d = fetchPc_q + STEP;
      if (push)  maskLow_d = 1'b0;
      if (pop) begin
        inst_d = headData;
        pc_d   = headPc;
      end else if (active && !stallIn) begin
        inst_d = BUBBLE;
      end
    end
    if (issue) flightPc_d = lsAddr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetchPc_q  <= '0;
      flightPc_q <= '0;
      inFlight_q <= 1'b0;
      maskLow_q  <= 1'b0;
      inst_q     <= BUBBLE;
      pc_q       <= '0;
    end else begin
      state_q    <= state_d;
      fetchPc_q  <= fetchPc_d;
      flightPc_q <= flightPc_d;
      inFlight_q <= inFlight_d;
      maskLow_q  <= maskLow_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
    end
  end

  assign instOut = inst_q;
  assign pcOut   = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random stall/branch traffic.
// A stream-level model predicts fetch addresses and the decoder pair sequence.
module tb_fetch_unit;

  localparam int AW = 15;
  localparam logic [63:0] ONES = '1;

  logic          clk = 1'b0;
  logic          reset, stallIn, branchTaken;
  logic [AW-1:0] branchTarget, lsAddr, pcOut;
  logic          lsReadEn;
  logic [63:0]   lsData, instOut;

  fetch_unit #(
    .instWidth  (32),
    .lsAddrWidth(AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stallIn     (stallIn),
    .branchTaken (branchTaken),
    .branchTarget(branchTarget),
    .lsReadEn    (lsReadEn),
    .lsAddr      (lsAddr),
    .lsData      (lsData),
    .instOut     (instOut),
    .pcOut       (pcOut)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  logic [AW-1:0] mIssue, mDeliver, lastPc;
  logic [63:0]   lastOut;
  logic          mMask, mActive, mStarted, prevRst;
  int            rc, need, outst;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory word n holds the value n.
  function automatic logic [63:0] pairAt(input logic [AW-1:0] a);
    logic [31:0] n;
    n = 32'(a >> 2);
    return {n + 32'd1, n};
  endfunction

  function automatic logic [AW-1:0] align8(input logic [AW-1:0] a);
    return {a[AW-1:3], 3'b000};
  endfunction

  task automatic modelReset();
    mIssue   = '0;
    mDeliver = '0;
    lastPc   = '0;
    lastOut  = ONES;
    mMask    = 1'b0;
    mActive  = 1'b0;
    mStarted = 1'b0;
    rc       = 0;
    need     = 4;
    outst    = 0;
  endtask

  task automatic tick();
    logic          re, brEff;
    logic [AW-1:0] a;
    logic [63:0]   exp;
    @(negedge clk);
    re    = lsReadEn;
    a     = lsAddr;
    brEff = branchTaken && mActive && !reset;
    if (reset) begin
      if (prevRst) begin
        chk("rst_rden", {63'b0, re}, 64'd0);
        chk("rst_addr", 64'(a), 64'd0);
      end
    end else begin
      if (brEff) begin
        mIssue = align8(branchTarget);
        outst  = 0;
      end
      if (re) begin
        chk("ls_addr", 64'(a), 64'(mIssue));
        mIssue = mIssue + 15'd8;
        outst++;
      end
    end
    @(posedge clk);
    #1;
    lsData = re ? pairAt(a) : {$urandom, $urandom};
    if (reset) begin
      chk("rst_inst", instOut, ONES);
      chk("rst_pc", 64'(pcOut), 64'd0);
      modelReset();
    end else if (brEff) begin
      chk("br_bubble", instOut, ONES);
      rc       = 1;
      need     = 3;
      mDeliver = align8(branchTarget);
      mMask    = branchTarget[2];
      mStarted = 1'b0;
      lastOut  = ONES;
    end else begin
      mActive = 1'b1;
      rc++;
      exp = pairAt(mDeliver);
      if (mMask) exp[31:0] = 32'hFFFF_FFFF;
      if (stallIn) begin
        chk("hold_inst", instOut, lastOut);
        chk("hold_pc", 64'(pcOut), 64'(lastPc));
      end else if (mStarted || rc >= need || instOut !== ONES) begin
        chk("pair", instOut, exp);
        chk("pair_pc", 64'(pcOut), 64'(mDeliver));
        lastOut  = exp;
        lastPc   = mDeliver;
        mDeliver = mDeliver + 15'd8;
        mMask    = 1'b0;
        mStarted = 1'b1;
        outst--;
      end else begin
        lastOut = ONES;
      end
      chk("occupancy", {63'b0, outst > 2}, 64'd0);
    end
    prevRst = reset;
  endtask

  task automatic run(input int n, input logic st);
    for (int i = 0; i < n; i++) begin
      stallIn     = st;
      branchTaken = 1'b0;
      tick();
    end
  endtask

  task automatic branch(input logic [AW-1:0] t);
    branchTaken  = 1'b1;
    branchTarget = t;
    stallIn      = 1'b0;
    tick();
    branchTaken  = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    stallIn      = 1'b0;
    branchTaken  = 1'b0;
    branchTarget = '0;
    lsData       = '0;
    prevRst      = 1'b0;
    modelReset();
    repeat (3) tick();
    reset = 1'b0;

    run(12, 1'b0);
    run(5, 1'b1);
    run(8, 1'b0);

    branch(15'h0104);
    run(6, 1'b0);

    branch(15'h7FF0);
    run(8, 1'b0);

    branch(15'h0040);
    branch(15'h0080);
    run(6, 1'b0);

    branch(15'h0204);
    run(3, 1'b1);
    run(6, 1'b0);

    for (int i = 0; i < 400; i++) begin
      stallIn      = ($urandom_range(0, 9) < 3);
      branchTaken  = ($urandom_range(0, 19) == 0);
      branchTarget = 15'($urandom & 32'h7FFC);
      tick();
    end
    branchTaken = 1'b0;
    run(6, 1'b0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    run(10, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
